// File: rtl/adc_scan_sequencer_if.sv
// Purpose : request/result channel between the scan sequencer and the ADC frame engine,
//           plus the sequencer's result-bank read port. Signal names are from the sequencer's side.
// Ports   : oSTART/oCH request; iBUSY/iDONE/iDATA engine status and result;
//           iRD_CH/oRD_DATA/oRD_FRESH result-bank read (1-cycle registered).
interface adc_scan_sequencer_if #(
    parameter int CH_W   = 3,
    parameter int DATA_W = 12
);
    logic              oSTART;
    logic [CH_W-1:0]   oCH;
    logic              iBUSY;
    logic              iDONE;
    logic [DATA_W-1:0] iDATA;
    logic [CH_W-1:0]   iRD_CH;
    logic [DATA_W-1:0] oRD_DATA;
    logic              oRD_FRESH;

    // Sequencer side.
    modport master (
        output oSTART, oCH, oRD_DATA, oRD_FRESH,
        input  iBUSY, iDONE, iDATA, iRD_CH
    );

    // Frame engine / bank reader side.
    modport slave (
        input  oSTART, oCH, oRD_DATA, oRD_FRESH,
        output iBUSY, iDONE, iDATA, iRD_CH
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Purpose     : round-robin scan of enabled ADC channels; one conversion request at a time,
//               12-bit results stored in a per-channel bank with fresh flags.
// Latency     : IDLE to oSTART in 2 cycles; bank read registered, 1 cycle.
// Backpressure: oSTART held off while iBUSY=1; a conversion aborts TIMEOUT cycles after oSTART.
// Ports       : iCLK, iRST (async, active-low); iENABLE/iCH_MASK/iPERIOD scan config;
//               io_adc engine handshake + bank read; oSCAN_DONE pulse; oTIMEOUT sticky.
module adc_scan_sequencer #(
    parameter int NUM_CH   = 8,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 64,
    parameter int DATA_W   = 12
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iENABLE,
    input  logic [NUM_CH-1:0]    iCH_MASK,
    input  logic [PERIOD_W-1:0]  iPERIOD,
    output logic                 oSCAN_DONE,
    output logic                 oTIMEOUT,
    adc_scan_sequencer_if.master io_adc
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = CH_W + 1;             // one extra bit so ptr can reach NUM_CH
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ARM,
        ST_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   r_scan_mask;
    logic [PTR_W-1:0]    r_ptr;
    logic [CH_W-1:0]     r_ch;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic                r_timeout;
    logic [DATA_W-1:0]   r_result [NUM_CH];
    logic [NUM_CH-1:0]   r_fresh;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_fresh;

    logic                w_found;
    logic [CH_W-1:0]     w_sel_ch;
    logic                w_start;
    logic                w_scan_done;
    logic                w_scan_go;
    logic                w_sel_load;
    logic                w_wr_en;
    logic                w_tmo_hit;
    logic                w_ptr_adv;

    // Lowest enabled channel at or above ptr; scanning downward lets the lowest index win.
    always_comb begin
        w_found  = 1'b0;
        w_sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_scan_mask[i] && (PTR_W'(i) >= r_ptr)) begin
                w_found  = 1'b1;
                w_sel_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_scan_done = 1'b0;
        w_scan_go   = 1'b0;
        w_sel_load  = 1'b0;
        w_wr_en     = 1'b0;
        w_tmo_hit   = 1'b0;
        w_ptr_adv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iENABLE && (iCH_MASK != '0) && (r_period_cnt == '0)) begin
                    w_scan_go   = 1'b1;
                    w_state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_found) begin
                    w_sel_load  = 1'b1;
                    w_state_nxt = ST_ARM;
                end else begin
                    w_scan_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARM: begin
                // Combinational so the request can never coincide with iBUSY=1.
                if (!io_adc.iBUSY) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still counts as done.
                if (io_adc.iDONE) begin
                    w_wr_en     = 1'b1;
                    w_ptr_adv   = 1'b1;
                    w_state_nxt = ST_SELECT;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_ptr_adv   = 1'b1;
                    w_state_nxt = ST_SELECT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Scan control datapath.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_scan_mask  <= '0;
            r_ptr        <= '0;
            r_ch         <= '0;
            r_tmo_cnt    <= '0;
            r_period_cnt <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_scan_go) begin
                r_scan_mask <= iCH_MASK;
                r_ptr       <= '0;
            end else if (w_ptr_adv) begin
                r_ptr <= {1'b0, r_ch} + PTR_W'(1);
            end

            if (w_sel_load) begin
                r_ch <= w_sel_ch;
            end

            // WAIT cycle k (from 0) holds k; the TIMEOUT-th WAIT cycle is the last chance.
            if (w_start) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end

            // Reload with iPERIOD-1 so scan-start decisions land exactly iPERIOD cycles apart.
            if (w_scan_go) begin
                r_period_cnt <= (iPERIOD == '0) ? '0 : iPERIOD - PERIOD_W'(1);
            end else if (r_period_cnt != '0) begin
                r_period_cnt <= r_period_cnt - PERIOD_W'(1);
            end

            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Result bank. Every cycle reads iRD_CH and consumes its fresh flag; a same-cycle
    // write to that channel is ordered last so the flag ends set, while the read
    // register still captures the pre-write data and flag.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_result[n] <= '0;
            end
            r_fresh    <= '0;
            r_rd_data  <= '0;
            r_rd_fresh <= 1'b0;
        end else begin
            r_rd_data              <= r_result[io_adc.iRD_CH];
            r_rd_fresh             <= r_fresh[io_adc.iRD_CH];
            r_fresh[io_adc.iRD_CH] <= 1'b0;
            if (w_wr_en) begin
                r_result[r_ch] <= io_adc.iDATA;
                r_fresh[r_ch]  <= 1'b1;
            end
        end
    end

    assign io_adc.oSTART    = w_start;
    assign io_adc.oCH       = r_ch;
    assign io_adc.oRD_DATA  = r_rd_data;
    assign io_adc.oRD_FRESH = r_rd_fresh;
    assign oSCAN_DONE       = w_scan_done;
    assign oTIMEOUT         = r_timeout;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Purpose : directed bench for adc_scan_sequencer with a behavioural frame engine.
// Latency : engine answers eng_lat cycles after each oSTART (or never for drop_mask channels).
// Backpressure: iBUSY driven directly by the stimulus.
module tb_adc_scan_sequencer;
    logic        iCLK     = 1'b0;
    logic        iRST     = 1'b0;
    logic        iENABLE  = 1'b0;
    logic [7:0]  iCH_MASK = '0;
    logic [15:0] iPERIOD  = '0;
    logic        oSCAN_DONE;
    logic        oTIMEOUT;

    adc_scan_sequencer_if bus ();

    adc_scan_sequencer dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iENABLE    (iENABLE),
        .iCH_MASK   (iCH_MASK),
        .iPERIOD    (iPERIOD),
        .oSCAN_DONE (oSCAN_DONE),
        .oTIMEOUT   (oTIMEOUT),
        .io_adc     (bus)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Frame engine model and event log, evaluated mid-cycle.
    int          eng_cnt   = 0;
    int          eng_lat   = 20;
    logic [11:0] eng_base  = 12'hA00;
    logic [7:0]  drop_mask = '0;
    logic [2:0]  eng_ch    = '0;
    int          start_cyc [$];
    int          start_ch  [$];
    int          n_scan_done = 0;

    always @(negedge iCLK) begin
        bus.iDONE <= 1'b0;
        if (eng_cnt == 1) begin
            bus.iDONE <= 1'b1;
            bus.iDATA <= eng_base + 12'(eng_ch);
        end
        if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
        if (bus.oSTART) begin
            start_cyc.push_back(cyc);
            start_ch.push_back(int'(bus.oCH));
            eng_ch  <= bus.oCH;
            eng_cnt <= drop_mask[bus.oCH] ? 0 : eng_lat;
        end
        if (oSCAN_DONE) n_scan_done <= n_scan_done + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int st_base  = 0;
    int sd_base  = 0;
    int t0       = 0;
    int found    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #2;
    endtask

    task automatic mark();
        st_base = start_ch.size();
        sd_base = n_scan_done;
    endtask

    function automatic int n_starts();
        return start_ch.size() - st_base;
    endfunction

    task automatic wait_starts(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && n_starts() < n; i++) tick();
        check(tag, n_starts(), n);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && (n_scan_done - sd_base) < n; i++) tick();
        check(tag, n_scan_done - sd_base, n);
    endtask

    task automatic read_ch(input logic [2:0] ch);
        bus.iRD_CH = ch;
        tick();
    endtask

    initial begin
        bus.iBUSY  = 1'b0;
        bus.iRD_CH = 3'd7;

        // Reset values
        repeat (3) tick();
        check("rst_start",   bus.oSTART,    0);
        check("rst_ch",      bus.oCH,       0);
        check("rst_rd_data", bus.oRD_DATA,  0);
        check("rst_fresh",   bus.oRD_FRESH, 0);
        check("rst_sdone",   oSCAN_DONE,    0);
        check("rst_tmo",     oTIMEOUT,      0);
        iRST = 1'b1;
        repeat (2) tick();

        // 1: mask 05, period 100
        mark();
        iCH_MASK = 8'h05;
        iPERIOD  = 16'd100;
        iENABLE  = 1'b1;
        t0       = cyc;
        wait_starts(3, 400, "t1_starts");
        check("t1_latency", start_cyc[st_base] - t0, 2);
        check("t1_ch_a",    start_ch[st_base],     0);
        check("t1_ch_b",    start_ch[st_base + 1], 2);
        check("t1_ch_c",    start_ch[st_base + 2], 0);
        check("t1_period",  start_cyc[st_base + 2] - start_cyc[st_base], 100);
        check("t1_one_done", n_scan_done - sd_base, 1);
        iENABLE = 1'b0;
        wait_done(2, 200, "t1_scan2_done");
        check("t1_scan2_ch2", start_ch[st_base + 3], 2);
        repeat (150) tick();
        check("t1_stopped", n_starts(), 4);
        read_ch(3'd0);
        check("t1_res0",   bus.oRD_DATA,  12'hA00);
        check("t1_fresh0", bus.oRD_FRESH, 1);
        tick();
        check("t1_fresh0_clr", bus.oRD_FRESH, 0);
        read_ch(3'd2);
        check("t1_res2",   bus.oRD_DATA,  12'hA02);
        check("t1_fresh2", bus.oRD_FRESH, 1);
        bus.iRD_CH = 3'd7;

        // 2: mask 80 wraps; mask 00 never starts
        mark();
        iPERIOD  = 16'd1000;
        iCH_MASK = 8'h80;
        iENABLE  = 1'b1;
        wait_starts(1, 50, "t2_start");
        iENABLE = 1'b0;
        wait_done(1, 100, "t2_done");
        check("t2_ch7", start_ch[st_base], 7);
        repeat (1000) tick();
        check("t2_single", n_starts(), 1);
        iCH_MASK = 8'h00;
        iPERIOD  = 16'd0;
        iENABLE  = 1'b1;
        repeat (1000) tick();
        check("t2_mask0_idle", n_starts(), 1);
        iCH_MASK = 8'h80;
        wait_starts(2, 5, "t2_resume");
        iENABLE = 1'b0;
        wait_done(2, 100, "t2_resume_done");

        // 3: iBUSY holds ARM for 50 cycles
        mark();
        bus.iBUSY = 1'b1;
        iCH_MASK  = 8'h01;
        iENABLE   = 1'b1;
        repeat (50) tick();
        check("t3_held", n_starts(), 0);
        iENABLE   = 1'b0;
        bus.iBUSY = 1'b0;
        t0        = cyc;
        wait_starts(1, 5, "t3_start");
        check("t3_first_free", start_cyc[st_base], t0);
        wait_done(1, 100, "t3_done");

        // iDONE on the last allowed cycle is a completion, not a timeout
        mark();
        eng_lat  = 64;
        eng_base = 12'hB00;
        iCH_MASK = 8'h01;
        iENABLE  = 1'b1;
        wait_starts(1, 10, "edge_start");
        iENABLE = 1'b0;
        wait_done(1, 200, "edge_done");
        check("edge_no_tmo", oTIMEOUT, 0);
        read_ch(3'd0);
        check("edge_res0", bus.oRD_DATA, 12'hB00);
        eng_lat  = 20;
        eng_base = 12'hA00;

        // 4: ch1 never answers
        mark();
        drop_mask = 8'h02;
        iCH_MASK  = 8'h0A;
        iENABLE   = 1'b1;
        wait_starts(1, 10, "t4_start");
        iENABLE = 1'b0;
        check("t4_ch1", start_ch[st_base], 1);
        t0 = start_cyc[st_base];
        for (int i = 0; i < 100 && cyc < t0 + 64; i++) tick();
        check("t4_tmo_early", oTIMEOUT, 0);
        tick();
        check("t4_tmo_set", oTIMEOUT, 1);
        wait_starts(2, 10, "t4_next");
        check("t4_ch3",     start_ch[st_base + 1], 3);
        check("t4_ch3_gap", start_cyc[st_base + 1] - t0, 66);
        wait_done(1, 100, "t4_done");
        drop_mask = 8'h00;
        read_ch(3'd1);
        check("t4_res1_kept", bus.oRD_DATA, 12'h000);
        read_ch(3'd3);
        check("t4_res3", bus.oRD_DATA, 12'hA03);

        // 5: mask 0F -> F0 mid-scan; read/write collision on ch2
        mark();
        bus.iRD_CH = 3'd2;
        eng_base   = 12'hD00;
        iCH_MASK   = 8'h0F;
        iENABLE    = 1'b1;
        wait_starts(2, 200, "t5_ch1_started");
        iCH_MASK = 8'hF0;
        found    = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (bus.iDONE === 1'b1 && bus.iDATA == 12'hD02) found = 1;
            else tick();
        end
        check("t5_coll_seen",      found,         1);
        check("t5_coll_old_data",  bus.oRD_DATA,  12'hA02);
        check("t5_coll_old_fresh", bus.oRD_FRESH, 0);
        tick();
        check("t5_coll_new_data",  bus.oRD_DATA,  12'hD02);
        check("t5_coll_new_fresh", bus.oRD_FRESH, 1);
        tick();
        check("t5_coll_consumed",  bus.oRD_FRESH, 0);
        wait_starts(5, 200, "t5_scan2_started");
        iENABLE = 1'b0;
        wait_done(2, 400, "t5_done");
        check("t5_total", n_starts(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("t5_ch%0d", i), start_ch[st_base + i], i);

        // 6: reset during WAIT, late iDONE ignored
        mark();
        bus.iRD_CH = 3'd3;
        eng_base   = 12'hC00;
        iCH_MASK   = 8'h02;
        iENABLE    = 1'b1;
        wait_starts(1, 10, "t6_start");
        iENABLE = 1'b0;
        repeat (5) tick();
        check("t6_pre_ch", bus.oCH, 1);
        iRST = 1'b0;
        #1;
        check("t6_rst_start",   bus.oSTART,    0);
        check("t6_rst_ch",      bus.oCH,       0);
        check("t6_rst_rd_data", bus.oRD_DATA,  0);
        check("t6_rst_fresh",   bus.oRD_FRESH, 0);
        check("t6_rst_sdone",   oSCAN_DONE,    0);
        check("t6_rst_tmo",     oTIMEOUT,      0);
        repeat (3) tick();
        iRST = 1'b1;
        repeat (40) tick();
        check("t6_no_start", n_starts(), 1);
        read_ch(3'd1);
        check("t6_late_done_ignored", bus.oRD_DATA,  12'h000);
        check("t6_late_fresh",        bus.oRD_FRESH, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
